// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline sequencer.
// Holds the sequencer state encoding and the default $v0 value that turns a
// syscall into a core halt.
package pipe_ctrl_pkg;

  // RUN: normal flow; MD_WAIT: frozen behind the mul/div unit; HALT: stopped
  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MD_WAIT = 2'd1,
    HALT    = 2'd2
  } pctl_state_t;

  localparam logic [31:0] EXIT_CODE_DEFAULT = 32'd10;

endpackage

// File: rtl/lu_hazard_detect.sv
// Load-use hazard comparator.
// Flags when the instruction in EX is a load whose destination register is
// read by the instruction currently in ID.
// Ports:
//   id_rs_i, id_rt_i           source registers of the ID instruction
//   id_rs_used_i, id_rt_used_i ID instruction really reads rs / rt
//   ex_ld_i, ex_reg_write_i    EX instruction is a load that writes the RF
//   ex_write_i                 destination register of the EX instruction
//   hazard_o                   1 = one bubble is required
module lu_hazard_detect #(
  parameter int REG_BITS = 5
) (
  input  logic [REG_BITS-1:0] id_rs_i,
  input  logic [REG_BITS-1:0] id_rt_i,
  input  logic                id_rs_used_i,
  input  logic                id_rt_used_i,
  input  logic                ex_ld_i,
  input  logic                ex_reg_write_i,
  input  logic [REG_BITS-1:0] ex_write_i,
  output logic                hazard_o
);

  logic rsMatch;
  logic rtMatch;

  // Register 0 is hardwired, so a load "into" it never creates a dependency.
  assign rsMatch  = id_rs_used_i && (id_rs_i == ex_write_i);
  assign rtMatch  = id_rt_used_i && (id_rt_i == ex_write_i);
  assign hazard_o = ex_ld_i && ex_reg_write_i && (ex_write_i != '0) && (rsMatch || rtMatch);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central pipeline sequencer for the 5-stage MIPS core.
// Drives load enables and bubble clears of the PC and the IF/ID, ID/EX and
// EX/MEM registers for load-use bubbles, taken-branch flushes, mul/div
// freezes and halt on the exit syscall, and keeps statistics counters.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   id_*                          ID-stage source register info
//   ex_*                          EX-stage instruction info
//   md_done / md_start            handshake with the mul/div unit
//   pc_en, if_id_en, id_ex_en     register load enables (1 = load)
//   if_id_zero .. ex_mem_zero     synchronous bubble loads (1 = bubble)
//   halted                        core stopped
//   cycle_cnt, stall_cnt, flush_cnt  wrapping statistics counters
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int          CNT_BITS  = 32,
  parameter int          REG_BITS  = 5,
  parameter logic [31:0] EXIT_CODE = EXIT_CODE_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [REG_BITS-1:0] id_rs,
  input  logic [REG_BITS-1:0] id_rt,
  input  logic                id_rs_used,
  input  logic                id_rt_used,
  input  logic                ex_ld,
  input  logic                ex_RegWrite,
  input  logic [REG_BITS-1:0] ex_write,
  input  logic                ex_branch_taken,
  input  logic                ex_Syscall,
  input  logic [31:0]         ex_v0,
  input  logic                ex_md_req,
  input  logic                md_done,
  output logic                md_start,
  output logic                pc_en,
  output logic                if_id_en,
  output logic                id_ex_en,
  output logic                if_id_zero,
  output logic                id_ex_zero,
  output logic                ex_mem_zero,
  output logic                halted,
  output logic [CNT_BITS-1:0] cycle_cnt,
  output logic [CNT_BITS-1:0] stall_cnt,
  output logic [CNT_BITS-1:0] flush_cnt
);

  pctl_state_t         state_q, state_d;
  logic [CNT_BITS-1:0] cycle_q, cycle_d;
  logic [CNT_BITS-1:0] stall_q, stall_d;
  logic [CNT_BITS-1:0] flush_q, flush_d;
  logic                luHazard;
  logic                exitSys;
  logic                flushInc;

  lu_hazard_detect #(.REG_BITS(REG_BITS)) u_lu (
    .id_rs_i        (id_rs),
    .id_rt_i        (id_rt),
    .id_rs_used_i   (id_rs_used),
    .id_rt_used_i   (id_rt_used),
    .ex_ld_i        (ex_ld),
    .ex_reg_write_i (ex_RegWrite),
    .ex_write_i     (ex_write),
    .hazard_o       (luHazard)
  );

  assign exitSys = ex_Syscall && (ex_v0 == EXIT_CODE);

  // Output decode and next state. Outputs are combinational so a hazard is
  // acted on at the same edge it is detected. Priority in RUN: exit syscall,
  // mul/div, taken branch (the ID instruction is then wrong-path, so it beats
  // load-use), load-use.
  always_comb begin
    state_d     = state_q;
    pc_en       = 1'b1;
    if_id_en    = 1'b1;
    id_ex_en    = 1'b1;
    if_id_zero  = 1'b0;
    id_ex_zero  = 1'b0;
    ex_mem_zero = 1'b0;
    md_start    = 1'b0;
    halted      = 1'b0;
    flushInc    = 1'b0;
    case (state_q)
      RUN: begin
        if (exitSys) begin
          pc_en    = 1'b0;
          if_id_en = 1'b0;
          id_ex_en = 1'b0;
          state_d  = HALT;
        end else if (ex_md_req) begin
          md_start    = 1'b1;
          pc_en       = 1'b0;
          if_id_en    = 1'b0;
          id_ex_en    = 1'b0;
          ex_mem_zero = 1'b1;
          state_d     = MD_WAIT;
        end else if (ex_branch_taken) begin
          if_id_zero = 1'b1;
          id_ex_zero = 1'b1;
          flushInc   = 1'b1;
        end else if (luHazard) begin
          pc_en      = 1'b0;
          if_id_en   = 1'b0;
          id_ex_zero = 1'b1;
        end
      end
      MD_WAIT: begin
        // On the done cycle the mul/div leaves EX with default outputs; the
        // still-high ex_md_req is deliberately not looked at here.
        if (md_done) begin
          state_d = RUN;
        end else begin
          pc_en       = 1'b0;
          if_id_en    = 1'b0;
          id_ex_en    = 1'b0;
          ex_mem_zero = 1'b1;
        end
      end
      HALT: begin
        pc_en       = 1'b0;
        if_id_en    = 1'b0;
        id_ex_en    = 1'b0;
        ex_mem_zero = 1'b1;
        halted      = 1'b1;
      end
      default: state_d = RUN;
    endcase
    // Reset holds every register frozen and loading bubbles.
    if (rst) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_en    = 1'b0;
      if_id_zero  = 1'b1;
      id_ex_zero  = 1'b1;
      ex_mem_zero = 1'b1;
      md_start    = 1'b0;
      halted      = 1'b0;
      flushInc    = 1'b0;
    end
  end

  // Statistics: counting stops once halted; all counters wrap naturally.
  always_comb begin
    cycle_d = cycle_q;
    stall_d = stall_q;
    flush_d = flush_q;
    if (state_q != HALT) begin
      cycle_d = cycle_q + CNT_BITS'(1);
      if (!pc_en) stall_d = stall_q + CNT_BITS'(1);
    end
    if (flushInc) flush_d = flush_q + CNT_BITS'(1);
  end

  // State and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      cycle_q <= '0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      cycle_q <= cycle_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign cycle_cnt = cycle_q;
  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl. The driver applies one directed
// vector per cycle and queues the hand-computed control outputs plus the
// expected counters; the monitor pops and compares on the falling edge.
// A second instance with 4-bit counters shares the stimulus to exercise wrap.
module tb_pipe_hazard_ctrl;

  // Control bundle bit order:
  // {pc_en, if_id_en, id_ex_en, if_id_zero, id_ex_zero, ex_mem_zero, md_start, halted}
  localparam int C_RUN   = 8'hE0;
  localparam int C_RST   = 8'h1C;
  localparam int C_LU    = 8'h28;
  localparam int C_BR    = 8'hF8;
  localparam int C_MDST  = 8'h06;
  localparam int C_FRZ   = 8'h04;
  localparam int C_HENT  = 8'h00;
  localparam int C_HALT  = 8'h05;

  typedef struct {
    string       name;
    logic [7:0]  ctl;
    logic [31:0] cyc;
    logic [31:0] stl;
    logic [31:0] fls;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [4:0]  id_rs, id_rt, ex_write;
  logic        id_rs_used, id_rt_used, ex_ld, ex_RegWrite;
  logic        ex_branch_taken, ex_Syscall, ex_md_req, md_done;
  logic [31:0] ex_v0;

  logic        mdStart, pcEn, ifIdEn, idExEn, ifIdZero, idExZero, exMemZero, haltedBig;
  logic [31:0] cycleBig, stallBig, flushBig;
  logic        mdStartS, pcEnS, ifIdEnS, idExEnS, ifIdZeroS, idExZeroS, exMemZeroS, haltedS;
  logic [3:0]  cycleS, stallS, flushS;

  exp_t        scoreboard[$];
  exp_t        cur;
  int          checkCount = 0;
  int          passCount  = 0;
  logic [31:0] expCycle = 0, expStall = 0, expFlush = 0;

  pipe_hazard_ctrl #(.CNT_BITS(32), .REG_BITS(5), .EXIT_CODE(32'd10)) dut (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .ex_ld(ex_ld),
    .ex_RegWrite(ex_RegWrite), .ex_write(ex_write),
    .ex_branch_taken(ex_branch_taken), .ex_Syscall(ex_Syscall), .ex_v0(ex_v0),
    .ex_md_req(ex_md_req), .md_done(md_done), .md_start(mdStart),
    .pc_en(pcEn), .if_id_en(ifIdEn), .id_ex_en(idExEn),
    .if_id_zero(ifIdZero), .id_ex_zero(idExZero), .ex_mem_zero(exMemZero),
    .halted(haltedBig), .cycle_cnt(cycleBig), .stall_cnt(stallBig), .flush_cnt(flushBig)
  );

  pipe_hazard_ctrl #(.CNT_BITS(4), .REG_BITS(5), .EXIT_CODE(32'd10)) dutSmall (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .ex_ld(ex_ld),
    .ex_RegWrite(ex_RegWrite), .ex_write(ex_write),
    .ex_branch_taken(ex_branch_taken), .ex_Syscall(ex_Syscall), .ex_v0(ex_v0),
    .ex_md_req(ex_md_req), .md_done(md_done), .md_start(mdStartS),
    .pc_en(pcEnS), .if_id_en(ifIdEnS), .id_ex_en(idExEnS),
    .if_id_zero(ifIdZeroS), .id_ex_zero(idExZeroS), .ex_mem_zero(exMemZeroS),
    .halted(haltedS), .cycle_cnt(cycleS), .stall_cnt(stallS), .flush_cnt(flushS)
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: counts it and reports a mismatch.
  task automatic checkOutput(input string name, input string field,
                             input logic [31:0] actual, input logic [31:0] required);
    checkCount++;
    if (actual === required) passCount++;
    else $display("[TB] FAIL %s.%s actual=%0h required=%0h", name, field, actual, required);
  endtask

  // Drive one vector just after the rising edge and queue its expected response,
  // then advance the counter model for the edge that ends this cycle.
  task automatic applyStimulus(input string name, input int r,
                               input int rs, input int rt, input int rsu, input int rtu,
                               input int ld, input int rw, input int wr,
                               input int br, input int sys, input int v0,
                               input int mdr, input int mdd, input int expCtl);
    exp_t e;
    logic [7:0] c;
    @(posedge clk);
    #1;
    rst             = r[0];
    id_rs           = 5'(rs);
    id_rt           = 5'(rt);
    id_rs_used      = rsu[0];
    id_rt_used      = rtu[0];
    ex_ld           = ld[0];
    ex_RegWrite     = rw[0];
    ex_write        = 5'(wr);
    ex_branch_taken = br[0];
    ex_Syscall      = sys[0];
    ex_v0           = 32'(v0);
    ex_md_req       = mdr[0];
    md_done         = mdd[0];
    c = 8'(expCtl);
    if (r != 0) begin
      expCycle = 0;
      expStall = 0;
      expFlush = 0;
    end
    e.name = name;
    e.ctl  = c;
    e.cyc  = expCycle;
    e.stl  = expStall;
    e.fls  = expFlush;
    scoreboard.push_back(e);
    if (r == 0 && !c[0]) begin
      expCycle = expCycle + 1;
      if (!c[7]) expStall = expStall + 1;
      if (c[4])  expFlush = expFlush + 1;
    end
  endtask

  // Monitor: compare both instances against the head of the scoreboard.
  always @(negedge clk) begin
    if (scoreboard.size() > 0) begin
      cur = scoreboard.pop_front();
      checkOutput(cur.name, "ctl",
                  {24'd0, pcEn, ifIdEn, idExEn, ifIdZero, idExZero, exMemZero, mdStart, haltedBig},
                  {24'd0, cur.ctl});
      checkOutput(cur.name, "cycle", cycleBig, cur.cyc);
      checkOutput(cur.name, "stall", stallBig, cur.stl);
      checkOutput(cur.name, "flush", flushBig, cur.fls);
      checkOutput(cur.name, "ctl4",
                  {24'd0, pcEnS, ifIdEnS, idExEnS, ifIdZeroS, idExZeroS, exMemZeroS, mdStartS, haltedS},
                  {24'd0, cur.ctl});
      checkOutput(cur.name, "cycle4", {28'd0, cycleS}, cur.cyc & 32'hF);
      checkOutput(cur.name, "stall4", {28'd0, stallS}, cur.stl & 32'hF);
      checkOutput(cur.name, "flush4", {28'd0, flushS}, cur.fls & 32'hF);
    end
  end

  initial begin
    rst = 1'b1;
    id_rs = '0; id_rt = '0; ex_write = '0;
    id_rs_used = 1'b0; id_rt_used = 1'b0; ex_ld = 1'b0; ex_RegWrite = 1'b0;
    ex_branch_taken = 1'b0; ex_Syscall = 1'b0; ex_v0 = '0;
    ex_md_req = 1'b0; md_done = 1'b0;

    //             name         r  rs rt su tu ld rw wr br sy v0 md dn expected
    applyStimulus("reset",      1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_RST);
    applyStimulus("idle",       0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_RUN);
    applyStimulus("lu_rs",      0, 8, 0, 1, 0, 1, 1, 8, 0, 0, 0, 0, 0, C_LU);
    applyStimulus("lu_bubble",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_RUN);
    applyStimulus("lu_r0",      0, 0, 0, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0, C_RUN);
    applyStimulus("lu_rt",      0, 3, 9, 1, 1, 1, 1, 9, 0, 0, 0, 0, 0, C_LU);
    applyStimulus("lu_unused",  0, 8, 0, 0, 0, 1, 1, 8, 0, 0, 0, 0, 0, C_RUN);
    applyStimulus("lu_noload",  0, 8, 0, 1, 0, 0, 1, 8, 0, 0, 0, 0, 0, C_RUN);
    applyStimulus("br_over_lu", 0, 8, 0, 1, 0, 1, 1, 8, 1, 0, 0, 0, 0, C_BR);
    applyStimulus("after_br",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_RUN);
    applyStimulus("md_start",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_MDST);
    applyStimulus("md_wait1",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_FRZ);
    applyStimulus("md_wait2",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_FRZ);
    applyStimulus("md_wait3",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_FRZ);
    applyStimulus("md_done",    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, C_RUN);
    applyStimulus("md_after",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_RUN);
    applyStimulus("md0_start",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, C_MDST);
    applyStimulus("md0_done",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, C_RUN);
    applyStimulus("stray_done", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, C_RUN);
    applyStimulus("sys_v0_1",   0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, C_RUN);
    applyStimulus("sys_exit",   0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 10, 0, 0, C_HENT);
    applyStimulus("halted",     0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_HALT);
    applyStimulus("halt_br",    0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, C_HALT);
    applyStimulus("halt_md",    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_HALT);
    applyStimulus("rst_halt",   1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_RST);
    applyStimulus("post_rst",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_RUN);
    applyStimulus("md_over_br", 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, C_MDST);
    applyStimulus("md_wait",    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_FRZ);
    applyStimulus("rst_mdwait", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_RST);
    applyStimulus("run_again",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_RUN);
    applyStimulus("run_again2", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_RUN);
    applyStimulus("sys_top",    0, 8, 0, 1, 0, 1, 1, 8, 1, 1, 10, 1, 0, C_HENT);
    applyStimulus("halted2",    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_HALT);
    applyStimulus("rst_wrap",   1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_RST);
    for (int i = 0; i < 18; i++) begin
      applyStimulus("wrap",     0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_RUN);
    end

    repeat (2) @(negedge clk);
    #1;
    checkOutput("drain", "pending", 32'(scoreboard.size()), 32'd0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
